// File: rtl/ls193.sv
// ls193: synchronous single-clock model of the SN74LS193 presettable 4-bit
// up/down binary counter with clear, parallel load and carry/borrow outputs.
// UP and DOWN are sampled as levels and edge-detected on clk.
// Optional feature: define LS193_SYNC_INPUT_EN to pass UP and DOWN through a
// two-flop synchronizer, reset high, before edge detection.
// Without the macro, the count latency is 1 cycle. With it, the latency is 3 cycles.
module ls193 (
  input  logic clk,
  input  logic reset,
  input  logic UP,
  input  logic DOWN,
  input  logic CLR,
  input  logic LOAD_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic QA,
  output logic QB,
  output logic QC,
  output logic QD,
  output logic CO_n,
  output logic BO_n
);

  // Count register and the previous effective UP/DOWN levels.
  logic [3:0] q_q;
  logic [3:0] q_d;
  logic       up_prev_q;
  logic       up_prev_d;
  logic       dn_prev_q;
  logic       dn_prev_d;

  // Effective (possibly synchronised) count levels and their rising edges.
  logic       up_eff;
  logic       dn_eff;
  logic       up_edge;
  logic       dn_edge;
  logic [3:0] load_val;

`ifdef LS193_SYNC_INPUT_EN
  logic up_s1_q;
  logic up_s1_d;
  logic up_s2_q;
  logic up_s2_d;
  logic dn_s1_q;
  logic dn_s1_d;
  logic dn_s2_q;
  logic dn_s2_d;

  // Next state of the two-stage synchronizers for UP and DOWN.
  always_comb begin
    up_s1_d = UP;
    up_s2_d = up_s1_q;
    dn_s1_d = DOWN;
    dn_s2_d = dn_s1_q;
  end

  // Synchronizer stages. They reset high so that reset cannot look like a count edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_s1_q <= 1'b1;
      up_s2_q <= 1'b1;
      dn_s1_q <= 1'b1;
      dn_s2_q <= 1'b1;
    end else begin
      up_s1_q <= up_s1_d;
      up_s2_q <= up_s2_d;
      dn_s1_q <= dn_s1_d;
      dn_s2_q <= dn_s2_d;
    end
  end

  assign up_eff = up_s2_q;
  assign dn_eff = dn_s2_q;
`else
  assign up_eff = UP;
  assign dn_eff = DOWN;
`endif

  assign load_val = {D, C, B, A};
  assign up_edge  = up_eff & ~up_prev_q;
  assign dn_edge  = dn_eff & ~dn_prev_q;

  // Next-count selection. Priority is clear, then load, then a legal up count,
  // then a legal down count. Illegal or simultaneous edges hold the count.
  always_comb begin
    q_d = q_q;
    if (CLR) begin
      q_d = 4'd0;
    end else if (!LOAD_n) begin
      q_d = load_val;
    end else if (up_edge && dn_eff && !dn_edge) begin
      q_d = q_q + 4'd1;
    end else if (dn_edge && up_eff && !up_edge) begin
      q_d = q_q - 4'd1;
    end
  end

  // Edge-detect history follows the effective levels every cycle.
  // As a result, an edge masked by clear or load is consumed and not deferred.
  always_comb begin
    up_prev_d = up_eff;
    dn_prev_d = dn_eff;
  end

  // State registers. Reset presets the history high, so that a fresh edge needs a low level first.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= 4'd0;
      up_prev_q <= 1'b1;
      dn_prev_q <= 1'b1;
    end else begin
      q_q       <= q_d;
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
    end
  end

  assign QA   = q_q[0];
  assign QB   = q_q[1];
  assign QC   = q_q[2];
  assign QD   = q_q[3];
  assign CO_n = ~((q_q == 4'd15) & ~up_prev_q);
  assign BO_n = ~((q_q == 4'd0) & ~dn_prev_q);

endmodule

// File: tb/tb_ls193.sv
// tb_ls193: table-driven, self-checking bench for ls193 with a scoreboard queue.
module tb_ls193;

  logic clk;
  logic reset;
  logic UP;
  logic DOWN;
  logic CLR;
  logic LOAD_n;
  logic A;
  logic B;
  logic C;
  logic D;
  logic QA;
  logic QB;
  logic QC;
  logic QD;
  logic CO_n;
  logic BO_n;

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    logic       clr;
    logic       load_n;
    logic [3:0] data;
    logic [3:0] exp_q;
    logic       exp_co;
    logic       exp_bo;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       co;
    logic       bo;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared;
  int   mismatched;

  ls193 dut (
    .clk(clk), .reset(reset), .UP(UP), .DOWN(DOWN), .CLR(CLR), .LOAD_n(LOAD_n),
    .A(A), .B(B), .C(C), .D(D),
    .QA(QA), .QB(QB), .QC(QC), .QD(QD), .CO_n(CO_n), .BO_n(BO_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic up, logic dn, logic clr, logic load_n,
                              logic [3:0] data, logic [3:0] q, logic co, logic bo, string name);
    vec_t v;
    v.rst = rst; v.up = up; v.dn = dn; v.clr = clr; v.load_n = load_n; v.data = data;
    v.exp_q = q; v.exp_co = co; v.exp_bo = bo; v.name = name;
    return v;
  endfunction

  task automatic compare(string name, logic [3:0] act, logic [3:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, and check it after the edge.
  task automatic applyStimulus(vec_t v);
    exp_t e;
    reset  = v.rst;
    UP     = v.up;
    DOWN   = v.dn;
    CLR    = v.clr;
    LOAD_n = v.load_n;
    {D, C, B, A} = v.data;
    e.q = v.exp_q; e.co = v.exp_co; e.bo = v.exp_bo; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      compare({e.name, ".q"},  {QD, QC, QB, QA}, e.q);
      compare({e.name, ".co"}, {3'b000, CO_n},   {3'b000, e.co});
      compare({e.name, ".bo"}, {3'b000, BO_n},   {3'b000, e.bo});
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1; UP = 1'b1; DOWN = 1'b1; CLR = 1'b0; LOAD_n = 1'b1;
    {D, C, B, A} = 4'd0;
    @(posedge clk);
    #1;

`ifdef LS193_SYNC_INPUT_EN
    vecs.push_back(mk(1, 1, 1, 0, 1, 4'h0, 4'd0, 1, 1, "reset"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h2, 4'd2, 1, 1, "load2"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd2, 1, 1, "uplow1"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd2, 1, 1, "uplow2"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd2, 1, 1, "uplow3"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd2, 1, 1, "uphigh_k"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd2, 1, 1, "sync_k1"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd3, 1, 1, "sync_k2_count"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd3, 1, 1, "sync_hold"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd3, 1, 1, "inflight"));
    vecs.push_back(mk(1, 0, 1, 0, 1, 4'h0, 4'd0, 1, 1, "reset_mid"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd0, 1, 1, "no_count1"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd0, 1, 1, "no_count2"));
`else
    vecs.push_back(mk(1, 1, 1, 0, 1, 4'h0, 4'd0,  1, 1, "reset"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hD, 4'd13, 1, 1, "load13"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd13, 1, 1, "up_low13"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd14, 1, 1, "up_to14"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd14, 1, 1, "up_low14"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd15, 1, 1, "up_to15"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd15, 0, 1, "carry_low"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd0,  1, 1, "wrap_to0"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'd0,  1, 0, "borrow_low"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd15, 1, 1, "wrap_to15"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'h0, 4'd15, 0, 1, "carry_again"));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h9, 4'd0,  1, 1, "clr_wins"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h6, 4'd6,  1, 1, "load6"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd6,  1, 1, "edge_consumed"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h5, 4'd5,  1, 1, "load5"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd5,  1, 1, "both_edges"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'd5,  1, 1, "both_low"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'd5,  1, 1, "up_dn_low"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd4,  1, 1, "down_to4"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'd4,  1, 1, "dn_low4"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd3,  1, 1, "down_to3"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'd0,  1, 0, "load0_borrow"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd15, 1, 1, "down_wrap"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'd15, 1, 1, "dn_low15"));
    vecs.push_back(mk(1, 1, 1, 0, 1, 4'h0, 4'd0,  1, 1, "reset_pending"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd0,  1, 1, "no_edge_after_rst"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'd0,  1, 0, "borrow_after_rst"));
    vecs.push_back(mk(1, 0, 1, 0, 1, 4'h0, 4'd0,  1, 1, "reset_up_low"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h0, 4'd0,  1, 1, "rst_blocks_edge"));
`endif

    foreach (vecs[i]) applyStimulus(vecs[i]);

`ifndef LS193_SYNC_INPUT_EN
    // Hand-written sequence: count at the maximum rate of clk/2 from 0 past the wrap.
    applyStimulus(mk(0, 1, 1, 0, 0, 4'h0, 4'd0, 1, 1, "seq_load0"));
    for (int i = 1; i <= 20; i++) begin
      logic [3:0] prev;
      logic [3:0] cur;
      prev = 4'((i - 1) % 16);
      cur  = 4'(i % 16);
      applyStimulus(mk(0, 0, 1, 0, 1, 4'h0, prev, (prev == 4'd15) ? 1'b0 : 1'b1, 1, "seq_low"));
      applyStimulus(mk(0, 1, 1, 0, 1, 4'h0, cur, 1, 1, "seq_high"));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
